// File: rtl/jtag_seq_pkg.sv
// Shared types and TMS header patterns for the JTAG scan sequencer.
package jtag_seq_pkg;

  typedef enum logic [1:0] {
    OP_RESET = 2'd0,
    OP_IR    = 2'd1,
    OP_DR    = 2'd2,
    OP_RSVD  = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_HDR,
    ST_SHIFT,
    ST_TRAIL,
    ST_RTI_WAIT,
    ST_RESP
  } seq_state_e;

  // Bit i is the TMS value driven on header step i, starting from Run-Test/Idle.
  localparam logic [3:0] DR_HDR_TMS = 4'b0001;
  localparam int         DR_HDR_LEN = 3;
  localparam logic [3:0] IR_HDR_TMS = 4'b0011;
  localparam int         IR_HDR_LEN = 4;
  localparam int         TRAIL_LEN  = 2;
  localparam int         IDLE_W     = 8;

  function automatic logic hdr_tms_bit(input cmd_op_e op, input logic [1:0] idx);
    return (op == OP_IR) ? IR_HDR_TMS[idx] : DR_HDR_TMS[idx];
  endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK divider: tck low then high for TCK_DIV clks each, with single-clk
// strobes on the clk where tck falls (fall_stb_o) and rises (rise_stb_o).
module jtag_tck_gen #(
  parameter int TCK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  output logic tck_o,
  output logic fall_stb_o,
  output logic rise_stb_o
);

  localparam int CNT_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tck_q, tck_d;
  logic             half_done;

  assign half_done = run_i && (cnt_q == CNT_W'(TCK_DIV - 1));

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    tck_d = tck_q;
    if (!run_i) begin
      cnt_d = '0;
      tck_d = 1'b0;
    end else if (half_done) begin
      cnt_d = '0;
      tck_d = ~tck_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tck_q <= tck_d;
    end
  end

  assign tck_o      = tck_q;
  assign rise_stb_o = half_done && !tck_q;
  assign fall_stb_o = half_done && tck_q;

endmodule

// File: rtl/jtag_scan_sequencer.sv
// JTAG master: runs TAP init, then IR/DR scans and TAP resets from a command channel.
// Optional macro JTAG_SEQ_IDLE_CYCLES_EN adds cmd_idle and the Run-Test/Idle wait.
module jtag_scan_sequencer
  import jtag_seq_pkg::*;
#(
  parameter int TCK_DIV = 2,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 6,
  parameter int TLR_CNT = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
`ifdef JTAG_SEQ_IDLE_CYCLES_EN
  input  logic [7:0]        cmd_idle,
`endif
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              busy,
  output logic              tck,
  output logic              tms,
  output logic              tdi,
  input  logic              tdo
);

  localparam int STEP_MAX0 = (DATA_W > TLR_CNT + 1) ? DATA_W : TLR_CNT + 1;
  localparam int STEP_MAX  = (STEP_MAX0 > 256) ? STEP_MAX0 : 256;
  localparam int STEP_W    = $clog2(STEP_MAX + 1);

  seq_state_e        state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  cmd_op_e           op_q, op_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] mask_q, mask_d;
  logic              tms_q, tms_d;
  logic              tdi_q, tdi_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic [IDLE_W-1:0] idle_cnt;

`ifdef JTAG_SEQ_IDLE_CYCLES_EN
  logic [IDLE_W-1:0] idle_q, idle_d;
  assign idle_cnt = idle_q;
`else
  assign idle_cnt = '0;
`endif

  logic              run, fall_stb, rise_stb;
  logic [STEP_W-1:0] step_inc, hdr_len;
  logic              hdr_next_tms, cmd_bad;
  seq_state_e        rti_next;

  jtag_tck_gen #(
    .TCK_DIV (TCK_DIV)
  ) u_tck_gen (
    .clk        (clk),
    .rst        (rst),
    .run_i      (run),
    .tck_o      (tck),
    .fall_stb_o (fall_stb),
    .rise_stb_o (rise_stb)
  );

  assign run = (state_q != ST_IDLE) && (state_q != ST_RESP);

  assign step_inc = step_q + STEP_W'(1);
  assign hdr_len  = (op_q == OP_RESET) ? STEP_W'(TLR_CNT + 1) :
                    (op_q == OP_IR)    ? STEP_W'(IR_HDR_LEN)  : STEP_W'(DR_HDR_LEN);

  // A zero-length scan raises TMS on the last header step: Capture -> Exit1.
  assign hdr_next_tms = (op_q == OP_RESET) ? (step_inc < STEP_W'(TLR_CNT)) :
                        (hdr_tms_bit(op_q, step_inc[1:0]) ||
                         ((len_q == '0) && (step_inc + STEP_W'(1) == hdr_len)));

  assign rti_next = (idle_cnt != '0) ? ST_RTI_WAIT : ST_RESP;
  assign cmd_bad  = (cmd_op_e'(cmd_op) == OP_RSVD) || (32'(cmd_len) > 32'(DATA_W));

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    op_d       = op_q;
    len_d      = len_q;
    data_d     = data_q;
    mask_d     = mask_q;
    tms_d      = tms_q;
    tdi_d      = tdi_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
`ifdef JTAG_SEQ_IDLE_CYCLES_EN
    idle_d     = idle_q;
`endif

    unique case (state_q)
      ST_INIT: begin
        if (fall_stb) begin
          if (step_inc == STEP_W'(TLR_CNT + 1)) begin
            state_d = ST_IDLE;
            step_d  = '0;
          end else begin
            step_d = step_inc;
            tms_d  = (step_inc < STEP_W'(TLR_CNT));
          end
        end
      end

      ST_IDLE: begin
        if (cmd_valid) begin
          op_d       = cmd_op_e'(cmd_op);
          len_d      = cmd_len;
          data_d     = cmd_data;
          mask_d     = DATA_W'(1);
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          step_d     = '0;
`ifdef JTAG_SEQ_IDLE_CYCLES_EN
          idle_d     = cmd_idle;
`endif
          if (cmd_bad) begin
            state_d   = ST_RESP;
            rsp_err_d = 1'b1;
          end else begin
            // Every header (reset, IR, DR) leaves Run-Test/Idle with TMS=1.
            state_d = ST_HDR;
            tms_d   = 1'b1;
          end
        end
      end

      ST_HDR: begin
        if (fall_stb) begin
          if (step_inc == hdr_len) begin
            step_d = '0;
            if (op_q == OP_RESET) begin
              state_d = rti_next;
            end else if (len_q == '0) begin
              state_d = ST_TRAIL;
              tms_d   = 1'b1;
            end else begin
              state_d = ST_SHIFT;
              tdi_d   = data_q[0];
              data_d  = data_q >> 1;
              tms_d   = (len_q == LEN_W'(1));
            end
          end else begin
            step_d = step_inc;
            tms_d  = hdr_next_tms;
          end
        end
      end

      ST_SHIFT: begin
        if (rise_stb) begin
          if (tdo) rsp_data_d = rsp_data_q | mask_q;
          mask_d = mask_q << 1;
        end
        if (fall_stb) begin
          if (step_inc == STEP_W'(len_q)) begin
            state_d = ST_TRAIL;
            step_d  = '0;
            tms_d   = 1'b1;
            tdi_d   = 1'b0;
          end else begin
            step_d = step_inc;
            tdi_d  = data_q[0];
            data_d = data_q >> 1;
            tms_d  = (step_inc + STEP_W'(1) == STEP_W'(len_q));
          end
        end
      end

      ST_TRAIL: begin
        if (fall_stb) begin
          if (step_inc == STEP_W'(TRAIL_LEN)) begin
            state_d = rti_next;
            step_d  = '0;
          end else begin
            step_d = step_inc;
            tms_d  = 1'b0;
          end
        end
      end

      ST_RTI_WAIT: begin
        if (fall_stb) begin
          if (step_inc == STEP_W'(idle_cnt)) begin
            state_d = ST_RESP;
            step_d  = '0;
          end else begin
            step_d = step_inc;
          end
        end
      end

      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      step_q     <= '0;
      op_q       <= OP_RESET;
      len_q      <= '0;
      data_q     <= '0;
      mask_q     <= '0;
      tms_q      <= 1'b1;
      tdi_q      <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
`ifdef JTAG_SEQ_IDLE_CYCLES_EN
      idle_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      op_q       <= op_d;
      len_q      <= len_d;
      data_q     <= data_d;
      mask_q     <= mask_d;
      tms_q      <= tms_d;
      tdi_q      <= tdi_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
`ifdef JTAG_SEQ_IDLE_CYCLES_EN
      idle_q     <= idle_d;
`endif
    end
  end

  assign cmd_ready = (state_q == ST_IDLE) && !rsp_valid;
  assign rsp_valid = (state_q == ST_RESP);
  assign busy      = run;
  assign tms       = tms_q;
  assign tdi       = tdi_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule
